// File: rtl/button_conditioner.sv
// Per-channel push-button conditioner: synchroniser, debouncer and press/release/hold strobes.
// Every channel is an independent copy of the same logic; all outputs are registered.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned HOLD_CYCLES     = 10000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] hold_pulse
);

  localparam int unsigned CntMax = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES
                                                                   : HOLD_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DebMax  = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_in;
    state_e                 state_q, state_d;
    logic [CntW-1:0]        dcnt_q, dcnt_d;
    logic [CntW-1:0]        hcnt_q, hcnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   hold_q, hold_d;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[g]};
      end
    end

    assign s_in = sync_q[SYNC_STAGES-1];

    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      hcnt_d  = hcnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      hold_d  = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s_in) begin
            state_d = StPressWait;
            dcnt_d  = CntW'(1);
          end
        end
        StPressWait: begin
          if (!s_in) begin
            state_d = StIdle;
            dcnt_d  = '0;
          end else if (dcnt_q == DebMax) begin
            state_d = StPressed;
            hcnt_d  = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        StPressed: begin
          if (!s_in) begin
            state_d = StReleaseWait;
            dcnt_d  = CntW'(1);
          end else if (hcnt_q != HoldMax) begin
            // Saturation at HoldMax makes the strobe one-shot; HoldMax=0 never counts.
            hcnt_d = hcnt_q + 1'b1;
            hold_d = (hcnt_d == HoldMax);
          end
        end
        StReleaseWait: begin
          if (s_in) begin
            state_d = StPressed;
            dcnt_d  = '0;
          end else if (dcnt_q == DebMax) begin
            state_d = StIdle;
            hcnt_d  = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= StIdle;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        hold_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        hold_q  <= hold_d;
      end
    end

    assign btn_level[g]     = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = rel_q;
    assign hold_pulse[g]    = hold_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected strobes with their cycle,
// a negedge monitor matches every observed strobe against the queue.
module tb_button_conditioner;

  localparam int KPress = 0;
  localparam int KRel   = 1;
  localparam int KHold  = 2;

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] hold_pulse;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  ev_t sb[$];

  button_conditioner #(
    .NUM_BTN        (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .hold_pulse   (hold_pulse)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; stable at every negedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int kind, input int ch, input int at);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Monitor: every strobe bit seen must match a queued expectation for this exact cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        for (int ch = 0; ch < 2; ch++) begin
          logic bitv;
          int   idx;
          case (k)
            KPress:  bitv = press_pulse[ch];
            KRel:    bitv = release_pulse[ch];
            default: bitv = hold_pulse[ch];
          endcase
          if (bitv === 1'b1) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
              if (idx < 0 && sb[i].kind == k && sb[i].ch == ch && sb[i].cyc == cyc) idx = i;
            end
            tests++;
            if (idx < 0) begin
              fails++;
              $display("FAIL mon_strobe kind=%0d ch=%0d: seen at cycle %0d, none expected then",
                       k, ch, cyc);
            end else begin
              sb.delete(idx);
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    int m;
    int p;
    int r;
    rst_n   = 1'b0;
    btn_raw = 2'b00;
    step(3);
    check("reset_level",   btn_level,     2'b00);
    check("reset_press",   press_pulse,   2'b00);
    check("reset_release", release_pulse, 2'b00);
    check("reset_hold",    hold_pulse,    2'b00);
    rst_n = 1'b1;
    step(3);

    // Clean press, held 30 cycles (hold strobe), then clean release.
    n = cyc;
    btn_raw[0] = 1'b1;
    push(KPress, 0, n + 7);
    push(KHold, 0, n + 17);
    step(6);
    check("t1_level_before", btn_level, 2'b00);
    step(1);
    check("t1_level_after", btn_level, 2'b01);
    check("t1_press", press_pulse, 2'b01);
    step(30);
    m = cyc;
    btn_raw[0] = 1'b0;
    push(KRel, 0, m + 7);
    step(6);
    check("t3_level_before_rel", btn_level, 2'b01);
    step(1);
    check("t3_level_after_rel", btn_level, 2'b00);
    check("t3_release", release_pulse, 2'b01);
    step(4);

    // Bounce: high 3, low 1, high 3, low -> nothing accepted.
    btn_raw[0] = 1'b1;
    step(3);
    btn_raw[0] = 1'b0;
    step(1);
    btn_raw[0] = 1'b1;
    step(3);
    btn_raw[0] = 1'b0;
    step(3);
    check("t2_level_mid", btn_level, 2'b00);
    step(5);
    check("t2_level_end", btn_level, 2'b00);

    // Release bounce while pressed; hold counter freezes during the 2-cycle dip.
    n = cyc;
    btn_raw[0] = 1'b1;
    push(KPress, 0, n + 7);
    step(7);
    p = cyc;
    btn_raw[0] = 1'b0;
    step(2);
    btn_raw[0] = 1'b1;
    push(KHold, 0, p + 13);
    check("t4_level_dip", btn_level, 2'b01);
    step(5);
    check("t4_level_recovered", btn_level, 2'b01);
    step(10);
    check("t4_level_late", btn_level, 2'b01);
    m = cyc;
    btn_raw[0] = 1'b0;
    push(KRel, 0, m + 7);
    step(8);
    check("t4_level_released", btn_level, 2'b00);

    // Reset mid-press on channel 1, button kept held.
    n = cyc;
    btn_raw[1] = 1'b1;
    push(KPress, 1, n + 7);
    step(9);
    check("t5_level_pressed", btn_level, 2'b10);
    rst_n = 1'b0;
    step(1);
    check("t5_rst_level",   btn_level,     2'b00);
    check("t5_rst_press",   press_pulse,   2'b00);
    check("t5_rst_release", release_pulse, 2'b00);
    check("t5_rst_hold",    hold_pulse,    2'b00);
    rst_n = 1'b1;
    r = cyc;
    push(KPress, 1, r + 7);
    push(KHold, 1, r + 17);
    step(6);
    check("t5_level_before", btn_level, 2'b00);
    step(1);
    check("t5_level_after", btn_level, 2'b10);
    step(20);
    m = cyc;
    btn_raw[1] = 1'b0;
    push(KRel, 1, m + 7);
    step(8);
    check("t5_level_released", btn_level, 2'b00);

    // Both channels together.
    n = cyc;
    btn_raw = 2'b11;
    push(KPress, 0, n + 7);
    push(KPress, 1, n + 7);
    push(KHold, 0, n + 17);
    push(KHold, 1, n + 17);
    step(7);
    check("t6_press_both", press_pulse, 2'b11);
    check("t6_level_both", btn_level, 2'b11);
    step(25);
    m = cyc;
    btn_raw = 2'b00;
    push(KRel, 0, m + 7);
    push(KRel, 1, m + 7);
    step(7);
    check("t6_release_both", release_pulse, 2'b11);
    step(5);
    check("t6_level_idle", btn_level, 2'b00);

    // Every queued strobe must have been seen by the monitor.
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d strobes never seen (first kind=%0d ch=%0d cyc=%0d), expected 0",
               sb.size(), sb[0].kind, sb[0].ch, sb[0].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
